// File: rtl/mem_port_if.sv
// Memory-side handshake bus of the shared instruction/data port.
// master: the arbiter driving requests; slave: the memory answering them.
interface mem_port_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  o_mem_valid;
  logic                  o_mem_we;
  logic [ADDR_WIDTH-1:0] o_mem_addr;
  logic [DATA_WIDTH-1:0] o_mem_wdata;
  logic                  i_mem_ready;
  logic [DATA_WIDTH-1:0] i_mem_rdata;

  modport master (
    output o_mem_valid, o_mem_we, o_mem_addr, o_mem_wdata,
    input  i_mem_ready, i_mem_rdata
  );

  modport slave (
    input  o_mem_valid, o_mem_we, o_mem_addr, o_mem_wdata,
    output i_mem_ready, i_mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Sequencing controller for the shared memory port of the multicycle core.
// Grants either the fetch requester (i_pc_next) or the load/store requester
// (i_result), holds a latched request on the memory bus until i_mem_ready,
// then pulses the matching done output with registered read data.
// Optional feature: define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration
// on simultaneous requests; otherwise data has fixed priority over fetch.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  arstn,
  input  logic                  i_fetch_req,
  input  logic [ADDR_WIDTH-1:0] i_pc_next,
  output logic                  o_fetch_done,
  input  logic                  i_data_req,
  input  logic                  i_data_we,
  input  logic [ADDR_WIDTH-1:0] i_result,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic                  o_data_done,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_addr_src,
  output logic                  o_busy,
  mem_port_if.master            mem
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DATA} state_e;

  state_e state_q, state_d;

  logic                  mem_valid_q, mem_valid_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  fetch_done_q, fetch_done_d;
  logic                  data_done_q, data_done_d;
  logic                  addr_src_q, addr_src_d;
  logic                  busy_q, busy_d;

  // A requester whose done pulse is high this cycle may not be regranted.
  logic fetch_elig, data_elig, grant_fetch, grant_data, mem_done;
  assign fetch_elig = i_fetch_req & ~fetch_done_q;
  assign data_elig  = i_data_req  & ~data_done_q;
  assign mem_done   = mem.i_mem_ready & (state_q != S_IDLE);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // 1 = data was granted last, 0 = fetch.
  logic last_grant_q, last_grant_d;

  // Pick the requester not granted last when both are eligible.
  always_comb begin
    grant_data  = data_elig & (~fetch_elig | ~last_grant_q);
    grant_fetch = fetch_elig & ~grant_data;
  end

  // Track the most recent grant.
  always_comb begin
    last_grant_d = last_grant_q;
    if (state_q == S_IDLE && grant_data)  last_grant_d = 1'b1;
    if (state_q == S_IDLE && grant_fetch) last_grant_d = 1'b0;
  end

  // Last-grant register; resets to data so fetch wins the first tie.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) last_grant_q <= 1'b1;
    else        last_grant_q <= last_grant_d;
  end
`else
  // Fixed priority: data always wins over fetch.
  always_comb begin
    grant_data  = data_elig;
    grant_fetch = fetch_elig & ~data_elig;
  end
`endif

  // State register.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state: grant from IDLE, return to IDLE when memory completes.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (grant_data)       state_d = S_DATA;
        else if (grant_fetch) state_d = S_FETCH;
      end
      S_FETCH, S_DATA: if (mem_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output next-values: latch request on grant, capture read data on completion.
  always_comb begin
    mem_valid_d  = mem_valid_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    rdata_d      = rdata_q;
    addr_src_d   = addr_src_q;
    fetch_done_d = 1'b0;
    data_done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (grant_data) begin
          mem_valid_d = 1'b1;
          mem_we_d    = i_data_we;
          mem_addr_d  = i_result;
          mem_wdata_d = i_wdata;
          addr_src_d  = 1'b1;
        end else if (grant_fetch) begin
          mem_valid_d = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = i_pc_next;
          mem_wdata_d = i_wdata;
          addr_src_d  = 1'b0;
        end
      end
      S_FETCH: if (mem_done) begin
        mem_valid_d  = 1'b0;
        rdata_d      = mem.i_mem_rdata;
        fetch_done_d = 1'b1;
      end
      S_DATA: if (mem_done) begin
        mem_valid_d = 1'b0;
        mem_we_d    = 1'b0;
        if (!mem_we_q) rdata_d = mem.i_mem_rdata;
        data_done_d = 1'b1;
      end
      default: mem_valid_d = 1'b0;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // Output registers; reset drops any pending transaction without a done pulse.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      mem_valid_q  <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      rdata_q      <= '0;
      addr_src_q   <= 1'b0;
      fetch_done_q <= 1'b0;
      data_done_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      mem_valid_q  <= mem_valid_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      rdata_q      <= rdata_d;
      addr_src_q   <= addr_src_d;
      fetch_done_q <= fetch_done_d;
      data_done_q  <= data_done_d;
      busy_q       <= busy_d;
    end
  end

  assign mem.o_mem_valid = mem_valid_q;
  assign mem.o_mem_we    = mem_we_q;
  assign mem.o_mem_addr  = mem_addr_q;
  assign mem.o_mem_wdata = mem_wdata_q;
  assign o_rdata         = rdata_q;
  assign o_addr_src      = addr_src_q;
  assign o_fetch_done    = fetch_done_q;
  assign o_data_done     = data_done_q;
  assign o_busy          = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: single fetch, waited store,
// simultaneous fetch+load arbitration, zero-wait load with held request,
// and asynchronous reset mid-transaction.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          arstn;
  logic          i_fetch_req, i_data_req, i_data_we;
  logic [AW-1:0] i_pc_next, i_result;
  logic [DW-1:0] i_wdata;
  logic          o_fetch_done, o_data_done, o_addr_src, o_busy;
  logic [DW-1:0] o_rdata;

  int n_chk  = 0;
  int n_fail = 0;

  mem_port_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mem ();

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk          (clk),
    .arstn        (arstn),
    .i_fetch_req  (i_fetch_req),
    .i_pc_next    (i_pc_next),
    .o_fetch_done (o_fetch_done),
    .i_data_req   (i_data_req),
    .i_data_we    (i_data_we),
    .i_result     (i_result),
    .i_wdata      (i_wdata),
    .o_data_done  (o_data_done),
    .o_rdata      (o_rdata),
    .o_addr_src   (o_addr_src),
    .o_busy       (o_busy),
    .mem          (mem)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".valid"}, mem.o_mem_valid, 0);
    chk({tag, ".we"},    mem.o_mem_we, 0);
    chk({tag, ".addr"},  mem.o_mem_addr, 0);
    chk({tag, ".wdata"}, mem.o_mem_wdata, 0);
    chk({tag, ".rdata"}, o_rdata, 0);
    chk({tag, ".src"},   o_addr_src, 0);
    chk({tag, ".fdone"}, o_fetch_done, 0);
    chk({tag, ".ddone"}, o_data_done, 0);
    chk({tag, ".busy"},  o_busy, 0);
  endtask

  logic first_is_data;

  initial begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
    first_is_data = 1'b0;
`else
    first_is_data = 1'b1;
`endif
    arstn = 1'b0;
    i_fetch_req = 0; i_data_req = 0; i_data_we = 0;
    i_pc_next = '0; i_result = '0; i_wdata = '0;
    mem.i_mem_ready = 0; mem.i_mem_rdata = '0;
    step();
    step();
    chk_all_zero("reset");
    arstn = 1'b1;
    step();
    chk("idle.busy", o_busy, 0);

    // Single fetch, ready one cycle after valid.
    i_fetch_req = 1; i_pc_next = 32'h100;
    step();
    chk("f1.valid", mem.o_mem_valid, 1);
    chk("f1.addr",  mem.o_mem_addr, 32'h100);
    chk("f1.src",   o_addr_src, 0);
    chk("f1.we",    mem.o_mem_we, 0);
    chk("f1.busy",  o_busy, 1);
    i_pc_next = 32'h999;
    step();
    chk("f1.hold", mem.o_mem_addr, 32'h100);
    chk("f1.nodone", o_fetch_done, 0);
    mem.i_mem_ready = 1; mem.i_mem_rdata = 32'h00500093;
    step();
    chk("f1.done",  o_fetch_done, 1);
    chk("f1.rdata", o_rdata, 32'h00500093);
    chk("f1.vclr",  mem.o_mem_valid, 0);
    chk("f1.busy0", o_busy, 0);
    i_fetch_req = 0; mem.i_mem_ready = 0;
    step();
    chk("f1.pulse", o_fetch_done, 0);

    // Store with 3 wait cycles; inputs scrambled after grant.
    i_data_req = 1; i_data_we = 1; i_result = 32'h2000; i_wdata = 32'hDEADBEEF;
    step();
    chk("st.valid", mem.o_mem_valid, 1);
    chk("st.src",   o_addr_src, 1);
    i_data_req = 0; i_result = 32'h1234; i_wdata = 32'h0; i_data_we = 0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("st.we%0d", i),    mem.o_mem_we, 1);
      chk($sformatf("st.addr%0d", i),  mem.o_mem_addr, 32'h2000);
      chk($sformatf("st.wdata%0d", i), mem.o_mem_wdata, 32'hDEADBEEF);
      chk($sformatf("st.valid%0d", i), mem.o_mem_valid, 1);
      if (i == 3) begin
        mem.i_mem_ready = 1; mem.i_mem_rdata = 32'h12345678;
      end
      step();
    end
    chk("st.done",  o_data_done, 1);
    chk("st.rdata", o_rdata, 32'h00500093);
    chk("st.vclr",  mem.o_mem_valid, 0);
    mem.i_mem_ready = 0;
    step();
    chk("st.pulse", o_data_done, 0);

    // Simultaneous fetch + load, both held until their done.
    i_fetch_req = 1; i_pc_next = 32'h300;
    i_data_req = 1; i_data_we = 0; i_result = 32'h400;
    step();
    chk("sim1.addr", mem.o_mem_addr, first_is_data ? 32'h400 : 32'h300);
    chk("sim1.src",  o_addr_src, first_is_data);
    mem.i_mem_ready = 1; mem.i_mem_rdata = 32'hAAAA0001;
    step();
    chk("sim1.ddone", o_data_done, first_is_data);
    chk("sim1.fdone", o_fetch_done, !first_is_data);
    chk("sim1.rdata", o_rdata, 32'hAAAA0001);
    if (first_is_data) i_data_req = 0; else i_fetch_req = 0;
    mem.i_mem_ready = 0;
    step();
    chk("sim2.valid", mem.o_mem_valid, 1);
    chk("sim2.addr",  mem.o_mem_addr, first_is_data ? 32'h300 : 32'h400);
    chk("sim2.src",   o_addr_src, !first_is_data);
    mem.i_mem_ready = 1; mem.i_mem_rdata = 32'hBBBB0002;
    step();
    chk("sim2.ddone", o_data_done, !first_is_data);
    chk("sim2.fdone", o_fetch_done, first_is_data);
    chk("sim2.rdata", o_rdata, 32'hBBBB0002);
    i_fetch_req = 0; i_data_req = 0; mem.i_mem_ready = 0;
    step();

    // Zero-wait load at 0x40, request held high after done.
    i_data_req = 1; i_data_we = 0; i_result = 32'h40;
    mem.i_mem_ready = 1; mem.i_mem_rdata = 32'h5555;
    step();
    chk("zw.valid", mem.o_mem_valid, 1);
    chk("zw.addr",  mem.o_mem_addr, 32'h40);
    step();
    chk("zw.done",  o_data_done, 1);
    chk("zw.rdata", o_rdata, 32'h5555);
    chk("zw.src",   o_addr_src, 1);
    mem.i_mem_ready = 0;
    step();
    chk("zw.nodup",  o_data_done, 0);
    chk("zw.idle",   mem.o_mem_valid, 0);
    chk("zw.srchold", o_addr_src, 1);
    step();
    chk("zw.regrant", mem.o_mem_valid, 1);
    chk("zw.nodup2",  o_data_done, 0);
    i_data_req = 0; mem.i_mem_ready = 1; mem.i_mem_rdata = 32'h6666;
    step();
    chk("zw.done2", o_data_done, 1);
    mem.i_mem_ready = 0;
    step();

    // Reset mid-DATA with ready never asserted.
    i_data_req = 1; i_data_we = 1; i_result = 32'h80; i_wdata = 32'h1;
    step();
    chk("rst.valid", mem.o_mem_valid, 1);
    step();
    #2;
    arstn = 1'b0;
    #1;
    chk_all_zero("rst.async");
    i_data_req = 0;
    step();
    chk("rst.nodone", o_data_done, 0);
    arstn = 1'b1;
    step();
    chk("rst.nodone2", o_data_done, 0);
    chk("rst.idle",    o_busy, 0);
    i_fetch_req = 1; i_pc_next = 32'h104;
    step();
    chk("rf.valid", mem.o_mem_valid, 1);
    chk("rf.addr",  mem.o_mem_addr, 32'h104);
    chk("rf.we",    mem.o_mem_we, 0);
    mem.i_mem_ready = 1; mem.i_mem_rdata = 32'h77;
    step();
    chk("rf.done",  o_fetch_done, 1);
    chk("rf.rdata", o_rdata, 32'h77);
    i_fetch_req = 0; mem.i_mem_ready = 0;
    step();
    chk("rf.pulse", o_fetch_done, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
